// File: rtl/axis_pkg.sv
// axis_pkg: shared state encoding, AXI constants and awsize helper for the write-address stage
package axis_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FWD, S_CALC, S_ADDR, S_DONE} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int AXI_4KB = 4096;
  function automatic logic [2:0] awsize(input int dw);
    return 3'($clog2(dw / 8));
  endfunction
endpackage

// File: rtl/axis_burst_calc.sv
// axis_burst_calc: burst length = min(beats_left, max burst[, beats to next 4KB boundary])
//   beats_left in  DW      beats still to issue
//   addr       in  AW      beat-aligned start address of the next burst
//   blen       out LW+1    beats in the next burst (1 .. 2**LW)
//   4KB term built only when AXIS_WRITE_ADDR_4K_EN is defined.
module axis_burst_calc
  import axis_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int LW     = 4,
  parameter int DATA_W = 64
) (
  input  logic [DW-1:0] beats_left,
  input  logic [AW-1:0] addr,
  output logic [LW:0]   blen
);
  localparam logic [DW-1:0] MAX_BEATS = DW'(2 ** LW);
  logic [DW-1:0] cap;
`ifdef AXIS_WRITE_ADDR_4K_EN
  logic [12:0] to_bnd;
  logic        unused_hi;
  assign unused_hi = ^addr[AW-1:12];
  always_comb begin
    to_bnd = (13'(AXI_4KB) - {1'b0, addr[11:0]}) >> awsize(DATA_W);
    cap = DW'(to_bnd) < MAX_BEATS ? DW'(to_bnd) : MAX_BEATS;
  end
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign cap = MAX_BEATS;
`endif
  assign blen = (LW+1)'(beats_left < cap ? beats_left : cap);
endmodule

// File: rtl/axis_write_addr.sv
// axis_write_addr: splits a stream-to-memory write command into AXI INCR address bursts
//   clk, rst_n                     clock, async active-low reset
//   cfg_address/length/valid/ready command in (byte address, length in stream words)
//   wcfg_length/valid/ready        word length forwarded once to the write-data stage
//   axi_aw*                        AXI write-address channel
//   done                           one-cycle pulse when the last burst address is accepted
//   Define AXIS_WRITE_ADDR_4K_EN to keep bursts inside 4KB pages.
module axis_write_addr
  import axis_pkg::*;
#(
  parameter int CONFIG_AWIDTH  = 32,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 4,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int WIDTH_RATIO    = 2,
  parameter int CONVERT_SHIFT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CONFIG_AWIDTH-1:0]  cfg_address,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [CONFIG_DWIDTH-1:0]  wcfg_length,
  output logic                      wcfg_valid,
  input  logic                      wcfg_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
  output logic [2:0]                axi_awsize,
  output logic [1:0]                axi_awburst,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic                      done
);
  localparam logic [2:0] SZ = awsize(AXI_DATA_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_MASK = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8 - 1);
  state_t state, nxt;
  logic live;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [CONFIG_DWIDTH-1:0] beats_left, len_q;
  logic [CONFIG_DWIDTH:0] beats_c;
  logic [AXI_LEN_WIDTH:0] blen, blen_c;
  logic accept;
  axis_burst_calc #(
    .DW(CONFIG_DWIDTH), .AW(AXI_ADDR_WIDTH), .LW(AXI_LEN_WIDTH), .DATA_W(AXI_DATA_WIDTH)
  ) u_calc (
    .beats_left(beats_left), .addr(addr), .blen(blen_c)
  );
  // live holds cfg_ready low during reset and for the clock that releases it
  assign cfg_ready   = live && state == S_IDLE;
  assign accept      = cfg_ready && cfg_valid;
  assign beats_c     = ({1'b0, cfg_length} + (CONFIG_DWIDTH+1)'(WIDTH_RATIO - 1)) >> CONVERT_SHIFT;
  assign wcfg_valid  = state == S_FWD;
  assign wcfg_length = len_q;
  assign axi_awvalid = state == S_ADDR;
  assign axi_awaddr  = addr;
  assign axi_awlen   = axi_awvalid ? AXI_LEN_WIDTH'(blen - 1'b1) : '0;
  assign axi_awsize  = SZ;
  assign axi_awburst = AXI_BURST_INCR;
  assign done        = state == S_DONE;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = accept ? (cfg_length == '0 ? S_DONE : S_FWD) : S_IDLE;
      S_FWD:   nxt = wcfg_ready ? S_CALC : S_FWD;
      S_CALC:  nxt = S_ADDR;
      S_ADDR:  nxt = axi_awready ? (beats_left == CONFIG_DWIDTH'(blen) ? S_DONE : S_CALC) : S_ADDR;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      live       <= 1'b0;
      addr       <= '0;
      beats_left <= '0;
      len_q      <= '0;
      blen       <= '0;
    end else begin
      state <= nxt;
      live  <= 1'b1;
      if (accept) begin
        addr       <= AXI_ADDR_WIDTH'(cfg_address) & ~BEAT_MASK;
        beats_left <= CONFIG_DWIDTH'(beats_c);
        len_q      <= cfg_length;
      end
      if (state == S_CALC) blen <= blen_c;
      if (axi_awvalid && axi_awready) begin
        addr       <= addr + (AXI_ADDR_WIDTH'(blen) << SZ);
        beats_left <= beats_left - CONFIG_DWIDTH'(blen);
      end
    end
  end
endmodule

// File: tb/tb_axis_write_addr.sv
// tb_axis_write_addr: directed checks of command split, stalls, zero length and reset abort
module tb_axis_write_addr;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] cfg_address, cfg_length;
  logic cfg_valid, cfg_ready;
  logic [31:0] wcfg_length;
  logic wcfg_valid, wcfg_ready;
  logic [31:0] axi_awaddr;
  logic [3:0] axi_awlen;
  logic [2:0] axi_awsize;
  logic [1:0] axi_awburst;
  logic axi_awvalid, axi_awready, done;
  int checks = 0, errors = 0;
  logic [31:0] aw_a[$];
  logic [3:0] aw_l[$];
  logic [31:0] w_q[$];
  int done_cnt = 0;

  always #5 clk = ~clk;

  axis_write_addr dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_address(cfg_address), .cfg_length(cfg_length), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .wcfg_length(wcfg_length), .wcfg_valid(wcfg_valid), .wcfg_ready(wcfg_ready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .done(done)
  );

  always @(posedge clk) if (rst_n) begin
    if (axi_awvalid && axi_awready) begin
      aw_a.push_back(axi_awaddr);
      aw_l.push_back(axi_awlen);
    end
    if (wcfg_valid && wcfg_ready) w_q.push_back(wcfg_length);
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // returns at the negedge right after the accepting edge
  task automatic send(input logic [31:0] a, input logic [31:0] l);
    int n = 0;
    @(negedge clk);
    cfg_address = a;
    cfg_length = l;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", cfg_ready, 1);
  endtask

  task automatic check_bursts(input string tag, input int base, input int cnt,
                              input logic [31:0] a[], input logic [3:0] l[]);
    chk({tag, "_count"}, 64'(aw_a.size() - base), 64'(cnt));
    for (int i = 0; i < cnt && base + i < aw_a.size(); i++) begin
      chk({tag, "_addr"}, aw_a[base+i], a[i]);
      chk({tag, "_len"}, aw_l[base+i], l[i]);
    end
  endtask

  task automatic test_single(input string tag);
    int ab = aw_a.size(), wb = w_q.size(), db = done_cnt, n = 1;
    send(32'h1000, 8);
    while (!axi_awvalid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_aw_latency"}, n, 3);
    chk({tag, "_awsize"}, axi_awsize, 3);
    chk({tag, "_awburst"}, axi_awburst, 2'b01);
    wait_done(20);
    chk({tag, "_wcfg_count"}, w_q.size() - wb, 1);
    if (w_q.size() > wb) chk({tag, "_wcfg_len"}, w_q[wb], 8);
    check_bursts(tag, ab, 1, '{32'h1000}, '{4'd3});
    chk({tag, "_done_count"}, done_cnt - db, 1);
  endtask

  initial begin
    int n, ab, wb, db;
    logic ok;
    logic [31:0] ea[], ref_a;
    logic [3:0] el[], ref_l;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_address = '0;
    cfg_length = '0;
    wcfg_ready = 1'b1;
    axi_awready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wcfg_valid", wcfg_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_awaddr", axi_awaddr, 0);
    chk("rst_awsize", axi_awsize, 3);
    chk("rst_awburst", axi_awburst, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_cfg_ready", cfg_ready, 1);

    test_single("t1");

    // 4092 words -> 2046 beats: 127 x 16 then 14
    ab = aw_a.size(); db = done_cnt;
    send(32'h0, 4092);
    wait_done(1000);
    ea = new[128]; el = new[128];
    for (int i = 0; i < 128; i++) begin
      ea[i] = 32'(i) * 32'h80;
      el[i] = i < 127 ? 4'd15 : 4'd13;
    end
    check_bursts("t2", ab, 128, ea, el);
    chk("t2_last_addr", ea[127], 32'h3F80);
    chk("t2_done_count", done_cnt - db, 1);

    ab = aw_a.size();
    send(32'h0FC0, 64);
    wait_done(100);
`ifdef AXIS_WRITE_ADDR_4K_EN
    check_bursts("t3", ab, 3, '{32'h0FC0, 32'h1000, 32'h1080}, '{4'd7, 4'd15, 4'd7});
`else
    check_bursts("t3", ab, 2, '{32'h0FC0, 32'h1040}, '{4'd15, 4'd15});
`endif

    // stalls; unaligned address rounds down to the beat
    ab = aw_a.size(); wb = w_q.size();
    wcfg_ready = 1'b0;
    axi_awready = 1'b0;
    send(32'h2004, 7);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ok &= wcfg_valid && !axi_awvalid && wcfg_length == 7;
      @(negedge clk);
    end
    chk("t4_wcfg_hold", ok, 1);
    wcfg_ready = 1'b1;
    n = 0;
    while (!axi_awvalid && n < 20) begin @(negedge clk); n++; end
    chk("t4_awvalid", axi_awvalid, 1);
    chk("t4_wcfg_dropped", wcfg_valid, 0);
    ref_a = axi_awaddr;
    ref_l = axi_awlen;
    chk("t4_awaddr", ref_a, 32'h2000);
    chk("t4_awlen", ref_l, 3);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ok &= axi_awvalid && axi_awaddr == 32'h2000 && axi_awlen == 4'd3;
    end
    chk("t4_aw_hold", ok, 1);
    axi_awready = 1'b1;
    wait_done(20);
    chk("t4_wcfg_count", w_q.size() - wb, 1);
    check_bursts("t4", ab, 1, '{32'h2000}, '{4'd3});

    // zero length: straight to DONE, nothing forwarded or issued
    ab = aw_a.size(); wb = w_q.size(); db = done_cnt;
    send(32'h3000, 0);
    chk("t5_done_next", done, 1);
    chk("t5_wcfg_valid", wcfg_valid, 0);
    chk("t5_awvalid", axi_awvalid, 0);
    @(negedge clk);
    chk("t5_done_pulse", done, 0);
    repeat (3) @(negedge clk);
    chk("t5_done_count", done_cnt - db, 1);
    chk("t5_no_wcfg", w_q.size() - wb, 0);
    chk("t5_no_aw", aw_a.size() - ab, 0);

    // reset mid-burst aborts without done
    axi_awready = 1'b0;
    send(32'h5000, 64);
    n = 0;
    while (!axi_awvalid && n < 20) begin @(negedge clk); n++; end
    chk("t6_awvalid_before", axi_awvalid, 1);
    db = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6_awvalid_async", axi_awvalid, 0);
    chk("t6_cfg_ready_rst", cfg_ready, 0);
    chk("t6_wcfg_valid_rst", wcfg_valid, 0);
    axi_awready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_cfg_ready_after", cfg_ready, 1);
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt - db, 0);
    test_single("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
